video_capture: RTL and testbench

- Sits directly downstream of the SNES core's video outputs in the cxxrtl simulation top.
- Samples R/G/B on each DOTCLK rising edge during active display (HBLANKn and VBLANKn both high).
- Tags each pixel with start-of-frame and end-of-line flags and buffers it in a small FIFO.
- Presents pixels on a valid/ready stream for the C++ harness to dump frames; also reports measured frame geometry and overflow.

---
 rtl/video_capture_pkg.sv | 17 +
 rtl/video_capture_fifo.sv | 65 ++++++
 rtl/video_capture.sv | 186 ++++++++++++++++++
 tb/tb_video_capture.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/video_capture_pkg.sv
// video_capture_pkg: types shared by video_capture and its pixel FIFO.
//   pix_t   - one captured pixel: start-of-frame flag, end-of-line flag, {R,G,B}
//   state_t - capture FSM state
package video_capture_pkg;

    typedef struct packed {
        logic        sof;
        logic        eol;
        logic [23:0] rgb;
    } pix_t;

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

endpackage

// File: rtl/video_capture_fifo.sv
// capture_fifo: synchronous show-ahead FIFO of pix_t.
//   clk_sys, RESET_N - clock, async active-low reset
//   push, din        - write request / data; accepted when not full, or when
//                      full with a pop in the same cycle
//   pop              - remove head (ignored when empty)
//   dout             - current head entry (valid when !empty)
//   full, empty      - derived from a registered occupancy count
module capture_fifo
    import video_capture_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic clk_sys,
    input  logic RESET_N,
    input  logic push,
    input  logic pop,
    input  pix_t din,
    output pix_t dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    pix_t          mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];

    // Pointers are AW bits wide so they wrap modulo FIFO_DEPTH on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is observable until count is non-zero.
    always_ff @(posedge clk_sys) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/video_capture.sv
// video_capture: samples SNES core video on DOTCLK rising edges during active
// display, tags pixels with sof/eol and streams them out through a FIFO.
//   clk_sys, RESET_N          - clock, async active-low reset
//   en                        - capture enable, looked at only on VBLANKn rise
//   DOTCLK, HBLANKn, VBLANKn  - core timing (levels, synchronous to clk_sys)
//   R, G, B                   - pixel colour
//   m_data/m_sof/m_eol/m_valid/m_ready - pixel stream out
//   overflow                  - sticky: a pixel was dropped on a full FIFO
//   frame_count               - completed captured frames (wraps)
//   last_width, last_height   - geometry of last completed line / frame
module video_capture
    import video_capture_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int XW         = 9,
    parameter int YW         = 9
) (
    input  logic          clk_sys,
    input  logic          RESET_N,
    input  logic          en,
    input  logic          DOTCLK,
    input  logic          HBLANKn,
    input  logic          VBLANKn,
    input  logic [7:0]    R,
    input  logic [7:0]    G,
    input  logic [7:0]    B,
    output logic [23:0]   m_data,
    output logic          m_sof,
    output logic          m_eol,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          overflow,
    output logic [15:0]   frame_count,
    output logic [XW-1:0] last_width,
    output logic [YW-1:0] last_height
);

    state_t        state_q, state_d;
    logic          dot_q, hb_q, vb_q;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          sof_pend_q, sof_pend_d;
    logic          hold_vld_q, hold_vld_d;
    pix_t          hold_q, hold_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [XW-1:0] last_w_q, last_w_d;
    logic [YW-1:0] last_h_q, last_h_d;

    logic pix_stb, hb_fall, vb_rise, vb_fall;
    logic push, pop, full, empty;
    pix_t push_pix, head;

    assign pix_stb = DOTCLK & ~dot_q;
    assign hb_fall = ~HBLANKn & hb_q;
    assign vb_rise = VBLANKn & ~vb_q;
    assign vb_fall = ~VBLANKn & vb_q;

    // Pixels are held back one strobe so the last pixel of a line can be
    // marked eol when HBLANKn falls. hb_fall and a pixel load are mutually
    // exclusive (load needs HBLANKn high), as are vb_fall and a load, so at
    // most one push happens per cycle.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        sof_pend_d  = sof_pend_q;
        hold_vld_d  = hold_vld_q;
        hold_d      = hold_q;
        overflow_d  = overflow_q;
        frame_cnt_d = frame_cnt_q;
        last_w_d    = last_w_q;
        last_h_d    = last_h_q;
        push        = 1'b0;
        push_pix    = hold_q;

        case (state_q)
            IDLE: begin
                if (vb_rise && en) begin
                    state_d    = CAPTURE;
                    x_d        = '0;
                    y_d        = '0;
                    sof_pend_d = 1'b1;
                end
            end
            CAPTURE: begin
                if (hb_fall) begin
                    if (hold_vld_q) begin
                        push         = 1'b1;
                        push_pix     = hold_q;
                        push_pix.eol = 1'b1;
                        hold_vld_d   = 1'b0;
                    end
                    // Lines with no active dots leave width/height untouched.
                    if (x_q != '0) begin
                        last_w_d = x_q;
                        y_d      = (y_q == {YW{1'b1}}) ? y_q : y_q + 1'b1;
                        x_d      = '0;
                    end
                end
                if (pix_stb && HBLANKn && VBLANKn) begin
                    if (hold_vld_q) begin
                        push     = 1'b1;
                        push_pix = hold_q;
                    end
                    hold_d     = '{sof: sof_pend_q, eol: 1'b0, rgb: {R, G, B}};
                    hold_vld_d = 1'b1;
                    sof_pend_d = 1'b0;
                    x_d        = (x_q == {XW{1'b1}}) ? x_q : x_q + 1'b1;
                end
                // Uses the _d view so a same-cycle hb_fall flush is not repeated.
                if (vb_fall) begin
                    if (hold_vld_d) begin
                        push         = 1'b1;
                        push_pix     = hold_d;
                        push_pix.eol = 1'b1;
                        hold_vld_d   = 1'b0;
                    end
                    if (y_d != '0) begin
                        last_h_d    = y_d;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push && full && !pop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            dot_q       <= 1'b0;
            hb_q        <= 1'b0;
            vb_q        <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            sof_pend_q  <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_q      <= '0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
            last_w_q    <= '0;
            last_h_q    <= '0;
        end else begin
            state_q     <= state_d;
            dot_q       <= DOTCLK;
            hb_q        <= HBLANKn;
            vb_q        <= VBLANKn;
            x_q         <= x_d;
            y_q         <= y_d;
            sof_pend_q  <= sof_pend_d;
            hold_vld_q  <= hold_vld_d;
            hold_q      <= hold_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
            last_w_q    <= last_w_d;
            last_h_q    <= last_h_d;
        end
    end

    capture_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_sys (clk_sys),
        .RESET_N (RESET_N),
        .push    (push),
        .pop     (pop),
        .din     (push_pix),
        .dout    (head),
        .full    (full),
        .empty   (empty)
    );

    assign m_valid     = ~empty;
    assign pop         = m_valid & m_ready;
    // Head is masked while empty so the stream outputs read 0 out of reset.
    assign m_data      = m_valid ? head.rgb : '0;
    assign m_sof       = m_valid & head.sof;
    assign m_eol       = m_valid & head.eol;
    assign overflow    = overflow_q;
    assign frame_count = frame_cnt_q;
    assign last_width  = last_w_q;
    assign last_height = last_h_q;

endmodule

// File: tb/tb_video_capture.sv
// Bench for video_capture (FIFO_DEPTH=4). Stimulus queues expected pixels;
// a negedge monitor pops and compares every accepted output beat.
module tb_video_capture;
    import video_capture_pkg::*;

    logic        clk_sys = 1'b0;
    logic        RESET_N = 1'b0;
    logic        en = 1'b0, DOTCLK = 1'b0, HBLANKn = 1'b0, VBLANKn = 1'b0;
    logic [7:0]  R = '0, G = '0, B = '0;
    logic [23:0] m_data;
    logic        m_sof, m_eol, m_valid;
    logic        m_ready = 1'b1;
    logic        overflow;
    logic [15:0] frame_count;
    logic [8:0]  last_width, last_height;

    int   n_cmp = 0;
    int   n_fail = 0;
    pix_t exp_q[$];
    bit   sof_next;

    video_capture #(.FIFO_DEPTH(4), .XW(9), .YW(9)) dut (
        .clk_sys(clk_sys), .RESET_N(RESET_N), .en(en), .DOTCLK(DOTCLK),
        .HBLANKn(HBLANKn), .VBLANKn(VBLANKn), .R(R), .G(G), .B(B),
        .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol), .m_valid(m_valid),
        .m_ready(m_ready), .overflow(overflow), .frame_count(frame_count),
        .last_width(last_width), .last_height(last_height)
    );

    always #5 clk_sys = ~clk_sys;

    // Scoreboard monitor: a beat is accepted at the next posedge.
    always @(negedge clk_sys) begin
        if (RESET_N && m_valid && m_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got sof=%0b eol=%0b rgb=%06h, want no beat",
                         m_sof, m_eol, m_data);
            end else begin
                pix_t e;
                e = exp_q.pop_front();
                if ({m_sof, m_eol, m_data} !== e)
                begin
                    n_fail++;
                    $display("FAIL pixel: got sof=%0b eol=%0b rgb=%06h, want sof=%0b eol=%0b rgb=%06h",
                             m_sof, m_eol, m_data, e.sof, e.eol, e.rgb);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] mk(input int tag, input int i);
        return {8'(tag), 8'(i), 8'h5A};
    endfunction

    // One line of n dots (DOTCLK 2 high / 2 low). Dots with index >= keep are
    // expected to be dropped. With coinc set, HBLANKn falls together with the
    // last dot's rising edge, so that dot is never captured.
    task automatic do_line(input int n, input int keep, input bit expd,
                           input int tag, input bit coinc);
        int eol_i;
        eol_i = coinc ? n - 2 : n - 1;
        HBLANKn = 1'b1;
        tick(2);
        for (int i = 0; i < n; i++) begin
            {R, G, B} = mk(tag, i);
            DOTCLK = 1'b1;
            if (coinc && i == n - 1) HBLANKn = 1'b0;
            else if (expd) begin
                if (i < keep) exp_q.push_back('{sof: sof_next, eol: (i == eol_i), rgb: mk(tag, i)});
                sof_next = 1'b0;
            end
            tick(2);
            DOTCLK = 1'b0;
            tick(2);
        end
        HBLANKn = 1'b0;
        tick(2);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            tick(1);
            k++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        tick(3);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frames", frame_count, 0);
        check("rst_width", last_width, 0);
        check("rst_height", last_height, 0);
        RESET_N = 1'b1;
        tick(2);

        // 4x2 frame, free-flowing output
        en = 1'b1; sof_next = 1'b1;
        VBLANKn = 1'b1; tick(2);
        do_line(4, 4, 1, 1, 0);
        do_line(4, 4, 1, 2, 0);
        VBLANKn = 1'b0; tick(3);
        drain();
        check("f1_width", last_width, 4);
        check("f1_height", last_height, 2);
        check("f1_frames", frame_count, 1);

        // en low at VBLANKn rise: whole frame ignored even if en rises later
        en = 1'b0;
        VBLANKn = 1'b1; tick(2);
        en = 1'b1;
        do_line(3, 3, 0, 3, 0);
        do_line(3, 3, 0, 4, 0);
        VBLANKn = 1'b0; tick(3);
        check("dis_frames", frame_count, 1);
        check("dis_width", last_width, 4);

        // stalled consumer: 4 retained, 2 dropped
        m_ready = 1'b0; sof_next = 1'b1;
        VBLANKn = 1'b1; tick(2);
        do_line(6, 4, 1, 5, 0);
        check("ovf_flag", overflow, 1);
        check("ovf_valid", m_valid, 1);
        check("ovf_head_a", {m_sof, m_eol, m_data}, {2'b10, mk(5, 0)});
        tick(5);
        check("ovf_head_b", {m_sof, m_eol, m_data}, {2'b10, mk(5, 0)});
        VBLANKn = 1'b0; tick(3);
        m_ready = 1'b1;
        drain();
        check("ovf_width", last_width, 6);
        check("ovf_frames", frame_count, 2);

        // HBLANKn falls with a dot edge: that dot is excluded
        sof_next = 1'b1;
        VBLANKn = 1'b1; tick(2);
        do_line(4, 4, 1, 6, 1);
        VBLANKn = 1'b0; tick(3);
        drain();
        check("coinc_width", last_width, 3);
        check("coinc_height", last_height, 1);

        // empty line between two 3-dot lines
        sof_next = 1'b1;
        VBLANKn = 1'b1; tick(2);
        do_line(3, 3, 1, 7, 0);
        do_line(0, 0, 1, 8, 0);
        do_line(3, 3, 1, 9, 0);
        VBLANKn = 1'b0; tick(3);
        drain();
        check("empty_height", last_height, 2);
        check("empty_width", last_width, 3);
        check("empty_frames", frame_count, 4);

        // reset mid-line with 3 entries queued and one held
        m_ready = 1'b0;
        VBLANKn = 1'b1; tick(2);
        HBLANKn = 1'b1; tick(2);
        for (int i = 0; i < 4; i++) begin
            {R, G, B} = mk(10, i);
            DOTCLK = 1'b1; tick(2);
            DOTCLK = 1'b0; tick(2);
        end
        check("pre_rst_valid", m_valid, 1);
        RESET_N = 1'b0;
        #1;
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_frames", frame_count, 0);
        check("mid_rst_width", last_width, 0);
        check("mid_rst_height", last_height, 0);
        HBLANKn = 1'b0; VBLANKn = 1'b0; m_ready = 1'b1;
        tick(2);
        RESET_N = 1'b1;
        tick(2);
        sof_next = 1'b1;
        VBLANKn = 1'b1; tick(2);
        do_line(2, 2, 1, 11, 0);
        VBLANKn = 1'b0; tick(3);
        drain();
        check("post_rst_frames", frame_count, 1);
        check("post_rst_width", last_width, 2);
        check("post_rst_height", last_height, 1);

        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
